// File: rtl/vload_sequencer.sv
// Issue-side sequencer for unit-stride vector loads: splits a byte length into
// lane-word read requests, throttles them with outstanding credits, counts returns.
module vload_sequencer #(
   parameter int MaxOutstanding = 4,
   parameter int AddrWidth      = 32,
   parameter int NrLane         = 4,
   parameter int ByteBlock      = 32,
   parameter int IdWidth        = 4,
   parameter int VlenWidth      = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 insn_valid_i,
   output logic                 insn_ready_o,
   input  logic [IdWidth-1:0]   insn_id_i,
   input  logic [AddrWidth-1:0] base_addr_i,
   input  logic [VlenWidth-1:0] vlB_i,
   output logic                 mem_req_valid_o,
   input  logic                 mem_req_ready_i,
   output logic [AddrWidth-1:0] mem_req_addr_o,
   output logic                 mem_req_last_o,
   input  logic                 rsp_fire_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [IdWidth-1:0]   done_insn_id_o
);

   localparam int WordB = ByteBlock / NrLane;
   localparam int CntW  = VlenWidth + $clog2(NrLane);
   localparam int OutW  = $clog2(MaxOutstanding + 1);
   localparam int VW1   = VlenWidth + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

   state_e               state_q;
   logic [CntW-1:0]      issued_q, returned_q, nbeat_q;
   logic [OutW-1:0]      outst_q;
   logic [AddrWidth-1:0] addr_q;
   logic [IdWidth-1:0]   id_q;

   logic                 accept, req_fire, rsp_ok;
   logic [VlenWidth:0]   blocks;
   logic [CntW-1:0]      nbeat_d, returned_d;
   logic [OutW-1:0]      outst_d;

   assign insn_ready_o    = (state_q == IDLE);
   assign busy_o          = (state_q != IDLE);
   assign done_o          = (state_q == DONE);
   assign done_insn_id_o  = id_q;
   assign mem_req_addr_o  = addr_q;
   assign mem_req_valid_o = (state_q == ISSUE) && (outst_q < OutW'(MaxOutstanding));
   assign mem_req_last_o  = mem_req_valid_o && (issued_q == nbeat_q - CntW'(1));

   assign accept   = insn_valid_i && insn_ready_o;
   assign req_fire = mem_req_valid_o && mem_req_ready_i;
   // Responses outside ISSUE/DRAIN or with no credit in flight are dropped.
   assign rsp_ok   = rsp_fire_i && ((state_q == ISSUE) || (state_q == DRAIN)) && (outst_q != '0);

   // Round up to whole blocks: vlu only pushes once every lane holds a word.
   assign blocks  = (VW1'(vlB_i) + VW1'(ByteBlock - 1)) / VW1'(ByteBlock);
   assign nbeat_d = CntW'(blocks) * CntW'(NrLane);

   assign returned_d = returned_q + CntW'(rsp_ok);

   always_comb begin
      outst_d = outst_q;
      if (req_fire && !rsp_ok)      outst_d = outst_q + OutW'(1);
      else if (!req_fire && rsp_ok) outst_d = outst_q - OutW'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         issued_q   <= '0;
         returned_q <= '0;
         outst_q    <= '0;
         nbeat_q    <= '0;
      end else begin
         outst_q    <= outst_d;
         returned_q <= returned_d;
         if (req_fire) issued_q <= issued_q + CntW'(1);
         case (state_q)
            IDLE: begin
               if (accept) begin
                  nbeat_q    <= nbeat_d;
                  issued_q   <= '0;
                  returned_q <= '0;
                  outst_q    <= '0;
                  state_q    <= (nbeat_d == '0) ? DONE : ISSUE;
               end
            end
            ISSUE:   if (req_fire && mem_req_last_o) state_q <= DRAIN;
            DRAIN:   if (returned_d == nbeat_q) state_q <= DONE;
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Address and id are datapath-only and carry no reset.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         addr_q <= base_addr_i;
         id_q   <= insn_id_i;
      end else if (req_fire) begin
         addr_q <= addr_q + AddrWidth'(WordB);
      end
   end

endmodule

// File: tb/tb_vload_sequencer.sv
// Randomized bench for vload_sequencer against a transaction-level model of
// beats, credits, addresses and completion timing.
module tb_vload_sequencer;
   localparam int MAXO = 4;
   localparam int NRL  = 4;
   localparam int BB   = 32;
   localparam int WB   = BB / NRL;
   localparam int AW   = 32;
   localparam int IDW  = 4;
   localparam int VW   = 16;

   logic           clk = 1'b0;
   logic           rst_ni = 1'b0;
   logic           insn_valid_i = 1'b0;
   logic           insn_ready_o;
   logic [IDW-1:0] insn_id_i = '0;
   logic [AW-1:0]  base_addr_i = '0;
   logic [VW-1:0]  vlB_i = '0;
   logic           mem_req_valid_o;
   logic           mem_req_ready_i = 1'b0;
   logic [AW-1:0]  mem_req_addr_o;
   logic           mem_req_last_o;
   logic           rsp_fire_i = 1'b0;
   logic           busy_o;
   logic           done_o;
   logic [IDW-1:0] done_insn_id_o;

   int total = 0;
   int bad = 0;
   int illegal_cnt = 0;

   vload_sequencer #(
      .MaxOutstanding(MAXO), .AddrWidth(AW), .NrLane(NRL),
      .ByteBlock(BB), .IdWidth(IDW), .VlenWidth(VW)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .insn_valid_i(insn_valid_i), .insn_ready_o(insn_ready_o),
      .insn_id_i(insn_id_i), .base_addr_i(base_addr_i), .vlB_i(vlB_i),
      .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
      .mem_req_addr_o(mem_req_addr_o), .mem_req_last_o(mem_req_last_o),
      .rsp_fire_i(rsp_fire_i), .busy_o(busy_o), .done_o(done_o),
      .done_insn_id_o(done_insn_id_o)
   );

   always #5 clk = ~clk;

   // Flags responses arriving while no instruction is in flight.
   always @(posedge clk)
      if (rst_ni && rsp_fire_i && (!busy_o || done_o)) illegal_cnt <= illegal_cnt + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic run_insn(input logic [IDW-1:0] id, input logic [AW-1:0] base, input int vlb,
                           input int rdy_pct, input int dmin, input int dmax, input int hold);
      int nbeat, issued, returned, done_due;
      bit fin;
      int rspq[$];
      logic [AW-1:0] exp_addr;
      nbeat    = ((vlb + BB - 1) / BB) * NRL;
      issued   = 0;
      returned = 0;
      done_due = -1;
      fin      = 1'b0;
      chk("idle_ready", insn_ready_o, 1);
      insn_valid_i = 1'b1;
      insn_id_i    = id;
      base_addr_i  = base;
      vlB_i        = VW'(vlb);
      @(posedge clk); @(negedge clk);
      insn_valid_i = 1'b0;
      if (nbeat == 0) done_due = 0;
      for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
         exp_addr = base + AW'(WB * issued);
         if (done_due >= 0 && cyc == done_due + 1) begin
            chk("ready_after_done", insn_ready_o, 1);
            chk("done_clear", done_o, 0);
            chk("busy_clear", busy_o, 0);
            fin = 1'b1;
         end else begin
            chk("busy", busy_o, 1);
            chk("ready_while_busy", insn_ready_o, 0);
            chk("req_valid", mem_req_valid_o, (issued < nbeat) && (issued - returned < MAXO));
            if (mem_req_valid_o) begin
               chk("req_addr", mem_req_addr_o, exp_addr);
               chk("req_last", mem_req_last_o, issued == nbeat - 1);
            end else begin
               chk("req_last_novalid", mem_req_last_o, 0);
            end
            chk("done", done_o, cyc == done_due);
            if (done_o) chk("done_id", done_insn_id_o, id);
            mem_req_ready_i = ($urandom_range(99) < rdy_pct);
            rsp_fire_i = 1'b0;
            if (rspq.size() > 0 && rspq[0] <= cyc && cyc >= hold) begin
               rsp_fire_i = 1'b1;
               void'(rspq.pop_front());
               returned++;
            end
            if (mem_req_valid_o && mem_req_ready_i) begin
               rspq.push_back(cyc + $urandom_range(dmax, dmin));
               issued++;
            end
            if (nbeat > 0 && done_due < 0 && returned == nbeat) done_due = cyc + 1;
            @(posedge clk); @(negedge clk);
         end
      end
      mem_req_ready_i = 1'b0;
      rsp_fire_i = 1'b0;
      if (!fin) chk("timeout", 0, 1);
      chk("beats_issued", issued, nbeat);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_ready", insn_ready_o, 1);
      chk("rst_valid", mem_req_valid_o, 0);
      chk("rst_last", mem_req_last_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      rst_ni = 1'b1;
      @(negedge clk);

      run_insn(4'h3, 32'h0000_1000, 64, 100, 2, 2, 0);
      run_insn(4'h4, 32'h0000_2000, 33, 100, 2, 2, 0);
      run_insn(4'h5, 32'h0000_3000, 0, 100, 2, 2, 0);
      run_insn(4'h6, 32'h0000_4000, 64, 100, 1, 1, 20);
      run_insn(4'h7, 32'h0000_5000, 96, 40, 1, 1, 0);
      run_insn(4'h8, 32'hFFFF_FFF8, 32, 100, 1, 3, 0);

      // Abort mid-issue with three requests in flight.
      insn_valid_i = 1'b1; insn_id_i = 4'h9; base_addr_i = 32'h0000_6000; vlB_i = 16'd64;
      mem_req_ready_i = 1'b1;
      @(posedge clk); @(negedge clk);
      insn_valid_i = 1'b0;
      repeat (3) begin @(posedge clk); @(negedge clk); end
      chk("pre_abort_valid", mem_req_valid_o, 1);
      mem_req_ready_i = 1'b0;
      rst_ni = 1'b0;
      #1;
      chk("abort_valid", mem_req_valid_o, 0);
      chk("abort_last", mem_req_last_o, 0);
      chk("abort_ready", insn_ready_o, 1);
      chk("abort_busy", busy_o, 0);
      chk("abort_done", done_o, 0);
      @(negedge clk);
      rst_ni = 1'b1;
      rsp_fire_i = 1'b1;
      repeat (2) begin
         @(posedge clk); @(negedge clk);
         chk("stray_valid", mem_req_valid_o, 0);
         chk("stray_done", done_o, 0);
         chk("stray_busy", busy_o, 0);
      end
      rsp_fire_i = 1'b0;
      chk("illegal_flagged", illegal_cnt, 2);
      run_insn(4'hA, 32'h0000_7000, 64, 100, 2, 2, 0);

      for (int i = 0; i < 8; i++)
         run_insn(IDW'(i), $urandom() & 32'hFFFF_FFF8, $urandom_range(200),
                  $urandom_range(100, 30), 1, 6, 0);

      chk("illegal_final", illegal_cnt, 2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
